// File: rtl/conv_seq_pkg.sv
// Shared state encoding and default geometry for the convolution sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} conv_state_t;

  localparam int XSIZE_D = 8;
  localparam int FSIZE_D = 4;

  // Samples produced from one loaded x/f pair.
  function automatic int num_outputs(input int xsize, input int fsize);
    return xsize - fsize + 1;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_load_ptr.sv
// Write pointer for one input vector memory; accepts SIZE words, then stalls.
// Latency: wr_en is combinational from s_valid; s_ready is registered.
// Backpressure: s_ready drops on the edge taking the last word and returns only when cleared into LOAD.
module load_ptr #(
  parameter int SIZE    = 8,
  parameter int LOGSIZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic               load_next,
  input  logic               hold,
  input  logic               clear,
  output logic               s_ready,
  output logic               wr_en,
  output logic [LOGSIZE-1:0] wr_addr,
  output logic               full_next
);

  localparam logic [LOGSIZE:0] LAST = (LOGSIZE+1)'(SIZE);

  logic [LOGSIZE:0] wp;
  logic [LOGSIZE:0] wp_next;

  assign wr_en   = s_valid & s_ready;
  assign wr_addr = wp[LOGSIZE-1:0];

  always_comb begin
    wp_next = wp;
    if (clear) begin
      wp_next = '0;
    end else if (wr_en) begin
      wp_next = wp + (LOGSIZE+1)'(1);
    end
  end

  // Looking at the next pointer lets the FSM leave LOAD on the same edge as the last write.
  assign full_next = (wp_next == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      s_ready <= 1'b0;
    end else begin
      wp      <= wp_next;
      s_ready <= load_next & ~hold & ~full_next;
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// One FSM owning x/f loading, tap-by-tap MAC control and sample handoff.
// Latency: FSIZE+1 cycles from COMPUTE entry to m_valid_y; FSIZE+2 cycles per sample with m_ready_y high.
// Backpressure: OUTPUT holds the accumulator until m_ready_y; inputs accepted only in LOAD.
// Build option CONV_SEQ_FREUSE_EN: keep the first f vector and reload only x on later batches.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int XSIZE = XSIZE_D,
  parameter int FSIZE = FSIZE_D,
  parameter int LOGX  = $clog2(XSIZE),
  parameter int LOGF  = $clog2(FSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid_x,
  output logic            s_ready_x,
  input  logic            s_valid_f,
  output logic            s_ready_f,
  output logic            wr_en_x,
  output logic            wr_en_f,
  output logic [LOGX-1:0] addr_x,
  output logic [LOGF-1:0] addr_f,
  output logic            clr_acc,
  output logic            en_acc,
  output logic            m_valid_y,
  input  logic            m_ready_y,
  output logic            busy
);

  localparam logic [LOGF:0] K_LAST = (LOGF+1)'(FSIZE);
  localparam logic [LOGX:0] J_LAST = (LOGX+1)'(XSIZE - FSIZE);

  conv_state_t     state;
  conv_state_t     state_next;
  logic [LOGX:0]   j;
  logic [LOGF:0]   k;
  logic            last_j;
  logic            batch_done;
  logic            load_next;
  logic            x_full_next;
  logic            f_full_next;
  logic            f_done;
  logic            f_hold;
  logic [LOGX-1:0] x_wr_addr;
  logic [LOGF-1:0] f_wr_addr;

  assign last_j     = (j == J_LAST);
  assign batch_done = (state == OUTPUT) & m_ready_y & last_j;
  assign load_next  = (state_next == LOAD);

`ifdef CONV_SEQ_FREUSE_EN
  logic f_loaded;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_loaded <= 1'b0;
    end else if (f_full_next) begin
      f_loaded <= 1'b1;
    end
  end

  assign f_hold = f_loaded;
  assign f_done = f_full_next | f_loaded;
`else
  assign f_hold = 1'b0;
  assign f_done = f_full_next;
`endif

  load_ptr #(
    .SIZE    (XSIZE),
    .LOGSIZE (LOGX)
  ) u_ptr_x (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid_x),
    .load_next (load_next),
    .hold      (1'b0),
    .clear     (batch_done),
    .s_ready   (s_ready_x),
    .wr_en     (wr_en_x),
    .wr_addr   (x_wr_addr),
    .full_next (x_full_next)
  );

  load_ptr #(
    .SIZE    (FSIZE),
    .LOGSIZE (LOGF)
  ) u_ptr_f (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid_f),
    .load_next (load_next),
    .hold      (f_hold),
    .clear     (batch_done),
    .s_ready   (s_ready_f),
    .wr_en     (wr_en_f),
    .wr_addr   (f_wr_addr),
    .full_next (f_full_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:    if (x_full_next && f_done) state_next = COMPUTE;
      COMPUTE: if (k == K_LAST) state_next = OUTPUT;
      OUTPUT:  if (m_ready_y) state_next = last_j ? LOAD : COMPUTE;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j <= '0;
      k <= '0;
    end else begin
      unique case (state)
        COMPUTE: k <= (k == K_LAST) ? '0 : k + (LOGF+1)'(1);
        OUTPUT: begin
          if (m_ready_y) begin
            k <= '0;
            j <= last_j ? '0 : j + (LOGX+1)'(1);
          end
        end
        default: begin
          j <= '0;
          k <= '0;
        end
      endcase
    end
  end

  // Reads lead the accumulate by one cycle, so the final COMPUTE cycle only adds.
  always_comb begin
    addr_x    = '0;
    addr_f    = '0;
    clr_acc   = 1'b0;
    en_acc    = 1'b0;
    m_valid_y = 1'b0;
    busy      = 1'b1;
    unique case (state)
      LOAD: begin
        addr_x = x_wr_addr;
        addr_f = f_wr_addr;
        busy   = 1'b0;
      end
      COMPUTE: begin
        if (k != K_LAST) begin
          addr_x = LOGX'(j) + LOGX'(k);
          addr_f = LOGF'(k);
        end
        clr_acc = (k == '0);
        en_acc  = (k != '0);
      end
      OUTPUT: begin
        m_valid_y = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with behavioural x/f memories, an 18-bit MAC and a result scoreboard.
module tb_conv_seq_ctrl;
  import conv_seq_pkg::*;

  localparam int XS   = XSIZE_D;
  localparam int FS   = FSIZE_D;
  localparam int NOUT = XS - FS + 1;

  typedef int xvec_t [XS];
  typedef int fvec_t [FS];

  logic       clk;
  logic       reset;
  logic       s_valid_x, s_valid_f;
  logic       s_ready_x, s_ready_f;
  logic       wr_en_x, wr_en_f;
  logic [2:0] addr_x;
  logic [1:0] addr_f;
  logic       clr_acc, en_acc;
  logic       m_valid_y, m_ready_y;
  logic       busy;
  logic [7:0] s_data_x, s_data_f;

  conv_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .s_valid_f (s_valid_f),
    .s_ready_f (s_ready_f),
    .wr_en_x   (wr_en_x),
    .wr_en_f   (wr_en_f),
    .addr_x    (addr_x),
    .addr_f    (addr_f),
    .clr_acc   (clr_acc),
    .en_acc    (en_acc),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: 1-cycle read memories and an 18-bit wrapping accumulator.
  logic [7:0]  xmem [XS];
  logic [7:0]  fmem [FS];
  logic [7:0]  xq, fq;
  logic [15:0] prod;
  logic [17:0] acc;
  int          cyc = 0;

  assign prod = {{8{xq[7]}}, xq} * {{8{fq[7]}}, fq};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_x) xmem[addr_x] <= s_data_x;
    if (wr_en_f) fmem[addr_f] <= s_data_f;
    xq <= xmem[addr_x];
    fq <= fmem[addr_f];
    if (clr_acc) acc <= '0;
    else if (en_acc) acc <= acc + {{2{prod[15]}}, prod};
  end

  int    checks = 0;
  int    failures = 0;
  int    last_wr = 0;
  int    exp_q[$];
  xvec_t cur_x;
  fvec_t cur_f;
  bit    f_needed = 1'b1;
  bit    x_junk = 1'b0;

  xvec_t xa = '{10, -20, 30, -40, 50, 60, 70, 80};
  fvec_t fa = '{10, 20, -30, 40};
  xvec_t xb = '{-90, 100, -110, 120, -50, 40, 30, -20};
  fvec_t fb = '{-50, -60, 70, 80};
  xvec_t xc = '{127, -128, 5, -7, 100, -100, 64, -64};
  fvec_t fc = '{-128, 127, -1, 2};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(input int j);
    int s;
    logic [17:0] t;
    s = 0;
    for (int kk = 0; kk < FS; kk++) s += cur_x[j + kk] * cur_f[kk];
    t = 18'(s);
    return int'($signed(t));
  endfunction

  task automatic check_zero(input string tag);
    check_bit({tag, "_rdy_x"}, s_ready_x, 1'b0);
    check_bit({tag, "_rdy_f"}, s_ready_f, 1'b0);
    check_bit({tag, "_wr_x"}, wr_en_x, 1'b0);
    check_bit({tag, "_wr_f"}, wr_en_f, 1'b0);
    check_val({tag, "_addr_x"}, 32'(addr_x), 0);
    check_val({tag, "_addr_f"}, 32'(addr_f), 0);
    check_bit({tag, "_clr"}, clr_acc, 1'b0);
    check_bit({tag, "_en"}, en_acc, 1'b0);
    check_bit({tag, "_valid"}, m_valid_y, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic load_batch(input xvec_t xv, input fvec_t fv, input int pct);
    int ix, jf, guard;
    ix = 0;
    jf = f_needed ? 0 : FS;
    guard = 0;
    cur_x = xv;
    if (f_needed) cur_f = fv;
    for (int j = 0; j < NOUT; j++) exp_q.push_back(ref_y(j));
    while ((ix < XS || jf < FS) && guard < 1000) begin
      @(negedge clk);
      guard++;
      m_ready_y = 1'b0;
      if (ix < XS) begin
        s_valid_x = (int'($urandom_range(99)) < pct);
        s_data_x  = 8'(xv[ix]);
      end else begin
        s_valid_x = 1'b1;
        s_data_x  = 'x;
      end
      if (jf < FS) begin
        s_valid_f = (int'($urandom_range(99)) < pct);
        s_data_f  = 8'(fv[jf]);
      end else begin
        s_valid_f = 1'b1;
        s_data_f  = 'x;
      end
      #1;
      check_bit("ld_rdy_x", s_ready_x, ix < XS);
      check_bit("ld_rdy_f", s_ready_f, jf < FS);
      check_bit("ld_wr_x", wr_en_x, s_valid_x && ix < XS);
      check_bit("ld_wr_f", wr_en_f, s_valid_f && jf < FS);
      check_bit("ld_busy", busy, 1'b0);
      if (s_valid_x && ix < XS) begin
        check_val("ld_addr_x", 32'(addr_x), ix);
        ix++;
        last_wr = cyc;
      end
      if (s_valid_f && jf < FS) begin
        check_val("ld_addr_f", 32'(addr_f), jf);
        jf++;
        last_wr = cyc;
      end
    end
    check_val("ld_words", ix + jf, XS + FS);
`ifdef CONV_SEQ_FREUSE_EN
    f_needed = 1'b0;
`endif
  endtask

  task automatic drain(input int n, input int pct, input bit timing);
    int got, guard, prev;
    got = 0;
    guard = 0;
    prev = 0;
    while (got < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      s_valid_x = x_junk;
      s_valid_f = x_junk;
      s_data_x  = 'x;
      s_data_f  = 'x;
      m_ready_y = (int'($urandom_range(99)) < pct);
      #1;
      if (x_junk) begin
        check_bit("busy_wr_x", wr_en_x, 1'b0);
        check_bit("busy_wr_f", wr_en_f, 1'b0);
      end
      if (m_valid_y) begin
        check_bit("out_acc_idle", clr_acc | en_acc, 1'b0);
        check_bit("out_busy", busy, 1'b1);
      end
      if (m_valid_y && m_ready_y) begin
        if (timing) begin
          if (got == 0) check_val("lat_first", cyc - last_wr, FS + 2);
          else check_val("spacing", cyc - prev, FS + 2);
        end
        prev = cyc;
        check_bit("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_val("y", int'($signed(acc)), exp_q.pop_front());
        got++;
      end
    end
    check_val("drain_count", got, n);
  endtask

  task automatic stall_output(input int cycles);
    int guard;
    logic [17:0] held;
    guard = 0;
    m_ready_y = 1'b0;
    while (!m_valid_y && guard < 200) begin
      @(negedge clk);
      guard++;
      s_valid_x = x_junk;
      s_valid_f = x_junk;
      s_data_x  = 'x;
      s_data_f  = 'x;
      #1;
      check_bit("junk_wr_x", wr_en_x, 1'b0);
      check_bit("junk_wr_f", wr_en_f, 1'b0);
    end
    check_bit("stall_reach", m_valid_y, 1'b1);
    held = acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      check_bit("stall_valid", m_valid_y, 1'b1);
      check_val("stall_acc", 32'(acc), 32'(held));
      check_bit("stall_en", en_acc, 1'b0);
      check_bit("stall_clr", clr_acc, 1'b0);
      check_bit("stall_wr_x", wr_en_x, 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    m_ready_y = 1'b0;
    s_data_x  = '0;
    s_data_f  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("rel_rdy_x_pre", s_ready_x, 1'b0);
    @(posedge clk);
    #1;
    check_bit("rel_rdy_x", s_ready_x, 1'b1);
    check_bit("rel_rdy_f", s_ready_f, 1'b1);

    // Back-to-back batch at full rate with latency and spacing checks.
    load_batch(xa, fa, 100);
    drain(NOUT, 100, 1'b1);

    // Second batch with valid/ready gaps (x only when f is reused), then idle.
    load_batch(xb, fb, 60);
    drain(NOUT, 60, 1'b0);
    m_ready_y = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      check_bit("idle_valid", m_valid_y, 1'b0);
    end
    check_bit("idle_busy", busy, 1'b0);

    // Long OUTPUT stall with stray X-data valids while not loading.
    load_batch(xc, fc, 80);
    x_junk = 1'b1;
    stall_output(20);
    drain(NOUT, 100, 1'b0);
    x_junk = 1'b0;

    // Reset while computing output j=2, then a clean batch.
    load_batch(xa, fb, 100);
    drain(2, 100, 1'b0);
    @(negedge clk);
    m_ready_y = 1'b0;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    #1;
    check_bit("mid_busy", busy, 1'b1);
    check_bit("mid_clr", clr_acc, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    #1;
    check_zero("mid_rst_hold");
    exp_q.delete();
    f_needed = 1'b1;
    reset = 1'b0;
    #1;
    check_bit("mid_rel_pre", s_ready_x, 1'b0);
    @(posedge clk);
    #1;
    check_bit("mid_rel_rdy_x", s_ready_x, 1'b1);
    load_batch(xb, fa, 100);
    drain(NOUT, 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
